// File: rtl/stage_mem.sv
// Memory-access stage of the in-order RV64 pipeline: stage register, single
// outstanding req/ack data-bus access, store lane shifting and load alignment.
module stage_mem #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_rd_en,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [1:0]      ex_mem_size,
  input  logic            ex_mem_unsigned,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            mem_stall,
  output logic            dbus_req,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_addr,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [XLEN/8-1:0] dbus_wstrb,
  input  logic            dbus_ack,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            mem_valid,
  output logic [XLEN-1:0] pc,
  output logic            rd_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] rd_value,
  output logic            mem_misalign
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state_q, state_d;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic            r_rd_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;
  logic            r_read;
  logic            r_write;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [XLEN-1:0] r_store_data;

  logic              mem_op;
  logic              is_store;
  logic              misalign_raw;
  logic              access;
  logic [OFF_W-1:0]  off;
  logic [STRB_W-1:0] size_mask;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_value;

  // Stage register: captures EX whenever the stage is not stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rd_en      <= 1'b0;
      r_rd         <= '0;
      r_result     <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_store_data <= '0;
    end else if (!mem_stall) begin
      r_valid      <= ex_valid;
      r_pc         <= ex_pc;
      r_rd_en      <= ex_rd_en;
      r_rd         <= ex_rd;
      r_result     <= ex_result;
      r_read       <= ex_mem_read;
      r_write      <= ex_mem_write;
      r_size       <= ex_mem_size;
      r_unsigned   <= ex_mem_unsigned;
      r_store_data <= ex_store_data;
    end
  end

  // Access state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE only when a request is not acked in its first cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !dbus_ack) state_d = WAIT;
      WAIT:    if (dbus_ack || !access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access classification, bus drive and load alignment (read+write acts as load)
  always_comb begin
    mem_op   = r_read | r_write;
    is_store = r_write & ~r_read;
    off      = r_result[OFF_W-1:0];

    misalign_raw = 1'b0;
    size_mask    = '0;
    case (r_size)
      2'd0: begin misalign_raw = 1'b0;        size_mask = STRB_W'(8'h01); end
      2'd1: begin misalign_raw = off[0];      size_mask = STRB_W'(8'h03); end
      2'd2: begin misalign_raw = |off[1:0];   size_mask = STRB_W'(8'h0F); end
      default: begin misalign_raw = |off;     size_mask = STRB_W'(8'hFF); end
    endcase
    misalign_raw = misalign_raw & mem_op;

    access    = r_valid & mem_op & ~misalign_raw;
    dbus_req  = access;
    mem_stall = access & ~dbus_ack;
    dbus_we   = access & is_store;
    dbus_addr = access ? {r_result[XLEN-1:OFF_W], OFF_W'(0)} : '0;
    dbus_wdata = dbus_we ? (r_store_data << {off, 3'b000}) : '0;
    dbus_wstrb = dbus_we ? (size_mask << off) : '0;

    ld_shift = dbus_rdata >> {off, 3'b000};
    ld_value = ld_shift;
    case (r_size)
      2'd0: ld_value = r_unsigned ? {{(XLEN-8){1'b0}},  ld_shift[7:0]}
                                  : {{(XLEN-8){ld_shift[7]}},  ld_shift[7:0]};
      2'd1: ld_value = r_unsigned ? {{(XLEN-16){1'b0}}, ld_shift[15:0]}
                                  : {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      2'd2: ld_value = r_unsigned ? {{(XLEN-32){1'b0}}, ld_shift[31:0]}
                                  : {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      default: ld_value = ld_shift;
    endcase

    mem_valid    = r_valid & (~mem_op | misalign_raw | dbus_ack);
    mem_misalign = r_valid & misalign_raw;
    rd_en        = mem_valid & r_rd_en & ~is_store & ~misalign_raw;
    pc           = r_pc;
    rd           = r_rd;
    rd_value     = (r_read && !misalign_raw) ? ld_value : r_result;
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with a completion scoreboard.
module tb_stage_mem;

  logic        clock, reset;
  logic        ex_valid, ex_rd_en, ex_mem_read, ex_mem_write, ex_mem_unsigned;
  logic [63:0] ex_pc, ex_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_size;
  logic        mem_stall, dbus_req, dbus_we, dbus_ack, mem_valid, rd_en, mem_misalign;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata, pc, rd_value;
  logic [7:0]  dbus_wstrb;
  logic [4:0]  rd;

  typedef struct packed {
    logic [63:0] pc;
    logic        rd_en;
    logic [4:0]  rd;
    logic [63:0] val;
    logic        chk_val;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  stage_mem #(.XLEN(64)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd_en(ex_rd_en), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_store_data(ex_store_data),
    .mem_stall(mem_stall), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_valid(mem_valid), .pc(pc), .rd_en(rd_en), .rd(rd),
    .rd_value(rd_value), .mem_misalign(mem_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] p, input logic re, input logic [4:0] d,
                      input logic [63:0] v, input logic cv, input logic m);
    exp_t e;
    e.pc = p; e.rd_en = re; e.rd = d; e.val = v; e.chk_val = cv; e.mis = m;
    sbq.push_back(e);
  endtask

  // Compare a completion against the scoreboard head, or check idle outputs
  task automatic check_wb();
    exp_t e;
    if (mem_valid) begin
      checks++;
      assert (sbq.size() > 0) else begin
        errors++;
        $error("FAIL sb_underflow: observed completion pc=%h expected none", pc);
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("wb_pc", pc, e.pc);
        chk("wb_rd_en", 64'(rd_en), 64'(e.rd_en));
        if (e.rd_en) chk("wb_rd", 64'(rd), 64'(e.rd));
        if (e.chk_val) chk("wb_rd_value", rd_value, e.val);
        chk("wb_misalign", 64'(mem_misalign), 64'(e.mis));
      end
    end else begin
      chk("idle_rd_en", 64'(rd_en), 64'd0);
      chk("idle_misalign", 64'(mem_misalign), 64'd0);
    end
  endtask

  // One clock: bus response applied after the edge, outputs sampled after settling
  task automatic cycle(input logic ack, input logic [63:0] rdata);
    @(posedge clock);
    #1;
    dbus_ack   = ack;
    dbus_rdata = rdata;
    #1;
    check_wb();
  endtask

  task automatic drive_ex(input logic [63:0] p, input logic re, input logic [4:0] d,
                          input logic [63:0] res, input logic rdf, input logic wrf,
                          input logic [1:0] sz, input logic u, input logic [63:0] sd);
    ex_valid = 1'b1; ex_pc = p; ex_rd_en = re; ex_rd = d; ex_result = res;
    ex_mem_read = rdf; ex_mem_write = wrf; ex_mem_size = sz;
    ex_mem_unsigned = u; ex_store_data = sd;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_pc = '0; ex_rd_en = 1'b0; ex_rd = '0; ex_result = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = '0;
    ex_mem_unsigned = 1'b0; ex_store_data = '0;
  endtask

  initial begin
    reset = 1'b1; dbus_ack = 1'b0; dbus_rdata = '0;
    drive_idle();

    // Reset state
    cycle(1'b0, 64'd0);
    cycle(1'b0, 64'd0);
    chk("rst_ctrl", 64'({mem_valid, mem_stall, dbus_req, dbus_we, rd_en, mem_misalign}), 64'd0);
    chk("rst_addr", dbus_addr, 64'd0);
    chk("rst_wdata", dbus_wdata, 64'd0);
    chk("rst_wstrb", 64'(dbus_wstrb), 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_rd_value", rd_value, 64'd0);
    reset = 1'b0;

    // ADD: completes the cycle it sits in the stage register
    drive_ex(64'h100, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0);
    push(64'h100, 1'b1, 5'd5, 64'h1234, 1'b1, 1'b0);
    cycle(1'b0, 64'd0);
    chk("add_stall", 64'(mem_stall), 64'd0);
    chk("add_valid", 64'(mem_valid), 64'd1);

    // LB then LBU at byte 3, same-cycle ack
    drive_ex(64'h104, 1'b1, 5'd6, 64'h1003, 1'b1, 1'b0, 2'd0, 1'b0, 64'd0);
    push(64'h104, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0);
    cycle(1'b1, 64'h0000_0000_8000_0000);
    chk("lb_req", 64'(dbus_req), 64'd1);
    chk("lb_we", 64'(dbus_we), 64'd0);
    chk("lb_addr", dbus_addr, 64'h1000);
    chk("lb_stall", 64'(mem_stall), 64'd0);
    drive_ex(64'h108, 1'b1, 5'd7, 64'h1003, 1'b1, 1'b0, 2'd0, 1'b1, 64'd0);
    push(64'h108, 1'b1, 5'd7, 64'h80, 1'b1, 1'b0);
    cycle(1'b1, 64'h0000_0000_8000_0000);
    chk("lbu_stall", 64'(mem_stall), 64'd0);

    // LH sign-extends, LWU zero-extends
    drive_ex(64'h10C, 1'b1, 5'd14, 64'h6002, 1'b1, 1'b0, 2'd1, 1'b0, 64'd0);
    push(64'h10C, 1'b1, 5'd14, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0);
    cycle(1'b1, 64'h0000_0000_8001_0000);
    drive_ex(64'h110, 1'b1, 5'd15, 64'h6004, 1'b1, 1'b0, 2'd2, 1'b1, 64'd0);
    push(64'h110, 1'b1, 5'd15, 64'h0000_0000_F000_0000, 1'b1, 1'b0);
    cycle(1'b1, 64'hF000_0000_1234_5678);
    chk("lwu_addr", dbus_addr, 64'h6000);

    // SH at 0x2006, ack after three stall cycles, ADD waiting behind it
    drive_ex(64'h114, 1'b1, 5'd8, 64'h2006, 1'b0, 1'b1, 2'd1, 1'b0, 64'hBEEF);
    push(64'h114, 1'b0, 5'd8, 64'd0, 1'b0, 1'b0);
    push(64'h118, 1'b1, 5'd9, 64'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 64'd0);
      if (i == 0) drive_ex(64'h118, 1'b1, 5'd9, 64'h55, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0);
      chk("sh_stall", 64'(mem_stall), 64'd1);
      chk("sh_req", 64'(dbus_req), 64'd1);
      chk("sh_we", 64'(dbus_we), 64'd1);
      chk("sh_addr", dbus_addr, 64'h2000);
      chk("sh_wdata", dbus_wdata, 64'hBEEF_0000_0000_0000);
      chk("sh_wstrb", 64'(dbus_wstrb), 64'hC0);
      chk("sh_no_valid", 64'(mem_valid), 64'd0);
    end
    cycle(1'b1, 64'd0);
    chk("sh_ack_stall", 64'(mem_stall), 64'd0);
    chk("sh_ack_valid", 64'(mem_valid), 64'd1);
    cycle(1'b0, 64'd0);
    chk("add2_valid", 64'(mem_valid), 64'd1);

    // Misaligned LW: no request, one-cycle flag
    drive_ex(64'h11C, 1'b1, 5'd10, 64'h3002, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0);
    push(64'h11C, 1'b0, 5'd10, 64'd0, 1'b0, 1'b1);
    cycle(1'b0, 64'd0);
    chk("mis_req", 64'(dbus_req), 64'd0);
    chk("mis_stall", 64'(mem_stall), 64'd0);
    chk("mis_flag", 64'(mem_misalign), 64'd1);
    drive_idle();
    cycle(1'b0, 64'd0);
    chk("mis_flag_drop", 64'(mem_misalign), 64'd0);
    chk("sb_empty_a", 64'(sbq.size()), 64'd0);

    // LD pending, reset mid-wait, late ack ignored
    drive_ex(64'h120, 1'b1, 5'd11, 64'h4000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
    cycle(1'b0, 64'd0);
    chk("ld_wait_stall", 64'(mem_stall), 64'd1);
    cycle(1'b0, 64'd0);
    chk("ld_wait_req", 64'(dbus_req), 64'd1);
    drive_idle();
    reset = 1'b1;
    cycle(1'b0, 64'd0);
    reset = 1'b0;
    chk("rst_mid_req", 64'(dbus_req), 64'd0);
    chk("rst_mid_valid", 64'(mem_valid), 64'd0);
    chk("rst_mid_stall", 64'(mem_stall), 64'd0);
    cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("late_ack_valid", 64'(mem_valid), 64'd0);

    // Back-to-back LD/LD, each acked on its first request cycle
    drive_ex(64'h124, 1'b1, 5'd12, 64'h5000, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
    push(64'h124, 1'b1, 5'd12, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    cycle(1'b1, 64'h0123_4567_89AB_CDEF);
    chk("ldld1_stall", 64'(mem_stall), 64'd0);
    drive_ex(64'h128, 1'b1, 5'd13, 64'h5008, 1'b1, 1'b0, 2'd3, 1'b1, 64'd0);
    push(64'h128, 1'b1, 5'd13, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    cycle(1'b1, 64'hFEDC_BA98_7654_3210);
    chk("ldld2_stall", 64'(mem_stall), 64'd0);
    chk("ldld2_addr", dbus_addr, 64'h5008);
    drive_idle();
    cycle(1'b0, 64'd0);
    chk("sb_empty_b", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
